// File: rtl/opalkelly_pipe_deframer_pkg.sv
// Shared definitions for the pipe deframer: FSM state encoding, default sync byte, beat layout.
package opalkelly_pipe_deframer_pkg;

   typedef enum logic [1:0] {
      StHunt    = 2'd0,
      StPayload = 2'd1,
      StCheck   = 2'd2
   } state_e;

   localparam logic [7:0]  DefaultSync = 8'hA5;

   typedef struct packed {
      logic [15:0] data;
      logic        first;
      logic        last;
   } beat_t;

   localparam int unsigned BeatWidth = $bits(beat_t);

   // A header carries the sync byte and a non-zero payload length.
   function automatic logic is_header(input logic [15:0] word, input logic [7:0] sync);
      return (word[15:8] == sync) && (word[7:0] != 8'd0);
   endfunction

endpackage

// File: rtl/opalkelly_pipe_deframer_if.sv
// Bridge-side pop handshake, payload stream and packet status of the pipe deframer.
interface opalkelly_pipe_deframer_if #(
   parameter int unsigned ERR_WIDTH = 8
);
   logic                 sys_rx_ready;
   logic                 sys_rx_valid;
   logic [15:0]          sys_rx;
   logic                 out_valid;
   logic                 out_ready;
   logic [15:0]          out_data;
   logic                 out_first;
   logic                 out_last;
   logic                 pkt_ok;
   logic                 pkt_err;
   logic [ERR_WIDTH-1:0] err_count;

   modport master (
      output sys_rx_ready, out_valid, out_data, out_first, out_last, pkt_ok, pkt_err, err_count,
      input  sys_rx_valid, sys_rx, out_ready
   );

   modport slave (
      input  sys_rx_ready, out_valid, out_data, out_first, out_last, pkt_ok, pkt_err, err_count,
      output sys_rx_valid, sys_rx, out_ready
   );
endinterface

// File: rtl/opalkelly_pipe_deframer_skid.sv
// Two-entry registered FIFO; push and pop may coincide at any occupancy, including full.
module pipe_skid_buffer #(
   parameter int unsigned WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   // When full, a push is only legal because the head leaves in the same cycle.
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 2'd1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/opalkelly_pipe_deframer.sv
// Parses header/payload/checksum packets from the pipe bridge and streams the payload out.
// Optional mid-packet idle abort: define OPALKELLY_PIPE_DEFRAMER_TIMEOUT_EN.
module opalkelly_pipe_deframer
   import opalkelly_pipe_deframer_pkg::*;
#(
   parameter logic [7:0]  SYNC      = DefaultSync,
   parameter int unsigned ERR_WIDTH = 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst_n,
   opalkelly_pipe_deframer_if.master      bus
);

   state_e               r_state, w_state_d;
   logic [7:0]           r_remaining, w_remaining_d;
   logic [15:0]          r_sum, w_sum_d;
   logic                 r_first, w_first_d;
   logic                 r_rx_ready;
   logic                 r_pkt_ok, w_pkt_ok_d;
   logic                 r_pkt_err, w_pkt_err_d;
   logic [ERR_WIDTH-1:0] r_err_count;
   logic                 w_err_inc;
   logic                 w_push;
   beat_t                w_push_beat;
   logic                 w_pop;
   logic [BeatWidth-1:0] w_head_raw;
   beat_t                w_head;
   logic [1:0]           w_count;
   logic                 w_empty;
   logic [1:0]           w_occupancy;
   logic                 w_rx_ready;

`ifdef OPALKELLY_PIPE_DEFRAMER_TIMEOUT_EN
   localparam int unsigned          IdleWidth = $clog2(TIMEOUT + 1);
   localparam logic [IdleWidth-1:0] IdleLast  = IdleWidth'(TIMEOUT - 1);
   logic [IdleWidth-1:0] r_idle, w_idle_d;
`endif

   // Every requested word is guaranteed a slot: in-flight request plus stored beats stay <= 2.
   assign w_occupancy = w_count + {1'b0, r_rx_ready};
   assign w_rx_ready  = sys_rst_n && (w_occupancy < 2'd2);

   always_comb begin
      w_state_d     = r_state;
      w_remaining_d = r_remaining;
      w_sum_d       = r_sum;
      w_first_d     = r_first;
      w_push        = 1'b0;
      w_push_beat   = '{data: bus.sys_rx, first: r_first, last: (r_remaining == 8'd1)};
      w_pkt_ok_d    = 1'b0;
      w_pkt_err_d   = 1'b0;
      w_err_inc     = 1'b0;
      if (bus.sys_rx_valid) begin
         unique case (r_state)
            StHunt: begin
               if (is_header(bus.sys_rx, SYNC)) begin
                  w_remaining_d = bus.sys_rx[7:0];
                  w_sum_d       = 16'd0;
                  w_first_d     = 1'b1;
                  w_state_d     = StPayload;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
            StPayload: begin
               w_push        = 1'b1;
               w_sum_d       = r_sum + bus.sys_rx;
               w_remaining_d = r_remaining - 8'd1;
               w_first_d     = 1'b0;
               if (r_remaining == 8'd1) begin
                  w_state_d = StCheck;
               end
            end
            StCheck: begin
               if (bus.sys_rx == r_sum) begin
                  w_pkt_ok_d = 1'b1;
               end else begin
                  w_pkt_err_d = 1'b1;
                  w_err_inc   = 1'b1;
               end
               w_state_d = StHunt;
            end
            default: w_state_d = StHunt;
         endcase
      end
`ifdef OPALKELLY_PIPE_DEFRAMER_TIMEOUT_EN
      w_idle_d = '0;
      if ((r_state != StHunt) && !bus.sys_rx_valid) begin
         if (r_idle == IdleLast) begin
            w_pkt_err_d = 1'b1;
            w_err_inc   = 1'b1;
            w_state_d   = StHunt;
         end else begin
            w_idle_d = r_idle + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= StHunt;
         r_remaining <= 8'd0;
         r_sum       <= 16'd0;
         r_first     <= 1'b0;
         r_rx_ready  <= 1'b0;
         r_pkt_ok    <= 1'b0;
         r_pkt_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_d;
         r_remaining <= w_remaining_d;
         r_sum       <= w_sum_d;
         r_first     <= w_first_d;
         r_rx_ready  <= w_rx_ready;
         r_pkt_ok    <= w_pkt_ok_d;
         r_pkt_err   <= w_pkt_err_d;
         if (w_err_inc && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
         end
      end
   end

`ifdef OPALKELLY_PIPE_DEFRAMER_TIMEOUT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_idle <= '0;
      end else begin
         r_idle <= w_idle_d;
      end
   end
`endif

   pipe_skid_buffer #(
      .WIDTH (BeatWidth)
   ) u_skid (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .i_push  (w_push),
      .i_data  (w_push_beat),
      .i_pop   (w_pop),
      .o_data  (w_head_raw),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign w_head = beat_t'(w_head_raw);
   assign w_pop  = bus.out_ready && !w_empty;

   assign bus.sys_rx_ready = w_rx_ready;
   assign bus.out_valid    = !w_empty;
   assign bus.out_data     = w_head.data;
   assign bus.out_first    = w_head.first;
   assign bus.out_last     = w_head.last;
   assign bus.pkt_ok       = r_pkt_ok;
   assign bus.pkt_err      = r_pkt_err;
   assign bus.err_count    = r_err_count;

endmodule
